panel_scan: RTL and testbench

PANEL_SCAN -- requirements
Module: panel_scan

---
 rtl/panel_scan.sv | 141 ++++++++++++++
 tb/tb_panel_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/panel_scan.sv
// rtl/panel_scan.sv - binary-coded-modulation scan driver for a 32x16, 1/8-scan LED panel
module panel_scan #(
   parameter int DEPTH = 4,
   parameter int UNIT  = 8
) (
   input  logic        pixclk,
   input  logic        reset,
   input  logic        display,
   output logic [9:0]  rd_addr,
   input  logic [23:0] rd_data,
   output logic        r1,
   output logic        g1,
   output logic        b1,
   output logic        r2,
   output logic        g2,
   output logic        b2,
   output logic        panel_clk,
   output logic        latch,
   output logic        oe_n,
   output logic [2:0]  row_sel,
   output logic        frame_done
);

   localparam int SHOW_MAX = UNIT << (DEPTH - 1);
   localparam int SW       = $clog2(SHOW_MAX + 1);

   localparam logic [2:0] FETCH_U = 3'd0;
   localparam logic [2:0] FETCH_L = 3'd1;
   localparam logic [2:0] SHIFT   = 3'd2;
   localparam logic [2:0] CLK     = 3'd3;
   localparam logic [2:0] LATCH   = 3'd4;
   localparam logic [2:0] SHOW    = 3'd5;

   localparam logic [2:0] LAST_P   = 3'(DEPTH - 1);
   localparam logic [2:0] BIT_BASE = 3'(8 - DEPTH);

   logic [2:0]    state;
   logic [4:0]    col;
   logic [2:0]    r;
   logic [2:0]    p;
   logic          page;
   logic [2:0]    row_q;
   logic [SW-1:0] cnt;
   logic [23:0]   upper;
   logic [23:0]   lower;

   logic          last_show;
   logic          data_en;
   logic [2:0]    bit_sel;
   logic [23:0]   lo_px;
   logic [7:0]    ur, ug, ub, lr, lg, lb;

   assign last_show = (state == SHOW) && (cnt == SW'(1));

   always_ff @(posedge pixclk) begin
      if (!reset) begin
         state <= FETCH_U;
         col   <= '0;
         r     <= '0;
         p     <= '0;
         page  <= display;
         row_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            FETCH_U: state <= FETCH_L;
            FETCH_L: begin
               upper <= rd_data;
               state <= SHIFT;
            end
            SHIFT: begin
               lower <= rd_data;
               state <= CLK;
            end
            CLK: begin
               if (col == 5'd31) begin
                  col   <= '0;
                  state <= LATCH;
               end else begin
                  col   <= col + 5'd1;
                  state <= FETCH_U;
               end
            end
            LATCH: begin
               row_q <= r;
               cnt   <= SW'(UNIT) << p;
               state <= SHOW;
            end
            SHOW: begin
               if (cnt == SW'(1)) begin
                  state <= FETCH_U;
                  if (p == LAST_P) begin
                     p <= '0;
                     if (r == 3'd7) begin
                        r    <= '0;
                        // page only follows the writer at a frame boundary
                        page <= display;
                     end else begin
                        r <= r + 3'd1;
                     end
                  end else begin
                     p <= p + 3'd1;
                  end
               end else begin
                  cnt <= cnt - SW'(1);
               end
            end
            default: state <= FETCH_U;
         endcase
      end
   end

   assign rd_addr = {page, (state == FETCH_L), r, col};

   // in SHIFT the lower pixel is still on rd_data; from CLK on it comes from the capture register
   assign lo_px   = (state == SHIFT) ? rd_data : lower;
   assign bit_sel = BIT_BASE + p;
   assign data_en = reset && ((state == SHIFT) || (state == CLK));

   assign ur = upper[23:16];
   assign ug = upper[15:8];
   assign ub = upper[7:0];
   assign lr = lo_px[23:16];
   assign lg = lo_px[15:8];
   assign lb = lo_px[7:0];

   assign r1 = data_en & ur[bit_sel];
   assign g1 = data_en & ug[bit_sel];
   assign b1 = data_en & ub[bit_sel];
   assign r2 = data_en & lr[bit_sel];
   assign g2 = data_en & lg[bit_sel];
   assign b2 = data_en & lb[bit_sel];

   // reset gates the strobes directly so an abort blanks the panel in the same cycle
   assign panel_clk  = reset && (state == CLK);
   assign latch      = reset && (state == LATCH);
   assign oe_n       = !(reset && (state == SHOW));
   assign row_sel    = reset ? row_q : 3'd0;
   assign frame_done = reset && last_show && (p == LAST_P) && (r == 3'd7);

endmodule

// File: tb/tb_panel_scan.sv
// tb/tb_panel_scan.sv - scoreboard bench for panel_scan with a synchronous framebuffer model
module tb_panel_scan;

   logic        pixclk = 1'b0;
   logic        reset;
   logic        display;
   logic [9:0]  rd_addr;
   logic [23:0] rd_data;
   logic        r1, g1, b1, r2, g2, b2;
   logic        panel_clk, latch, oe_n, frame_done;
   logic [2:0]  row_sel;

   logic [23:0] mem [0:1023];

   logic [5:0]  exp_bits[$];
   int          exp_show[$];
   logic [2:0]  exp_row[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int ones_r1, ones_r2;

   panel_scan #(.DEPTH(4), .UNIT(8)) dut (
      .pixclk(pixclk), .reset(reset), .display(display),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
      .panel_clk(panel_clk), .latch(latch), .oe_n(oe_n),
      .row_sel(row_sel), .frame_done(frame_done)
   );

   always #5 pixclk = ~pixclk;

   always @(posedge pixclk) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic pg);
      for (int rr = 0; rr < 8; rr++) begin
         for (int pp = 0; pp < 4; pp++) begin
            for (int c = 0; c < 32; c++) begin
               logic [23:0] u;
               logic [23:0] l;
               int b;
               u = mem[{pg, 1'b0, 3'(rr), 5'(c)}];
               l = mem[{pg, 1'b1, 3'(rr), 5'(c)}];
               b = 4 + pp;
               exp_bits.push_back({u[16+b], u[8+b], u[b], l[16+b], l[8+b], l[b]});
            end
            exp_show.push_back(8 << pp);
            exp_row.push_back(3'(rr));
         end
      end
   endtask

   task automatic wait_frame(input logic pg, input int toggle_at);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 6000 && !seen; n++) begin
         @(negedge pixclk);
         if (n == toggle_at) display = 1'b1;
         check("page_stable", 32'(rd_addr[9]), 32'(pg));
         if (frame_done) seen = 1'b1;
      end
      check("frame_done_seen", 32'(seen), 1);
      check("bits_drained", exp_bits.size(), 0);
   endtask

   // monitor: data bits on panel_clk rises, show lengths, row_sel, frame period
   bit prev_pclk;
   int low_run, rises, cyc, last_fd;
   always @(negedge pixclk) begin
      if (!mon_en) begin
         prev_pclk = 1'b0;
         low_run   = 0;
         rises     = 0;
         cyc       = 0;
         last_fd   = -1;
      end else begin
         cyc++;
         if (panel_clk && !prev_pclk) begin
            rises++;
            if (r1) ones_r1++;
            if (r2) ones_r2++;
            if (exp_bits.size() == 0) check("bits_queue", 0, 1);
            else check("pixel_bits", 32'({r1, g1, b1, r2, g2, b2}), 32'(exp_bits.pop_front()));
         end
         if (latch) begin
            check("rises_per_plane", rises, 32);
            rises = 0;
         end
         if (!oe_n) begin
            check("oe_exclusive", 32'({panel_clk, latch}), 0);
            if (low_run == 0) begin
               if (exp_row.size() == 0) check("row_queue", 0, 1);
               else check("row_sel", 32'(row_sel), 32'(exp_row.pop_front()));
            end
            low_run++;
         end else if (low_run != 0) begin
            if (exp_show.size() == 0) check("show_queue", 0, 1);
            else check("show_len", low_run, exp_show.pop_front());
            low_run = 0;
         end
         if (frame_done) begin
            if (last_fd >= 0) check("frame_period", cyc - last_fd, 5088);
            last_fd = cyc;
         end
         prev_pclk = panel_clk;
      end
   end

   initial begin
      bit found;
      reset   = 1'b0;
      display = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 24'h0;

      repeat (3) @(negedge pixclk);
      check("rst_oe_n", 32'(oe_n), 1);
      check("rst_panel_clk", 32'(panel_clk), 0);
      check("rst_latch", 32'(latch), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_row_sel", 32'(row_sel), 0);
      check("rst_bits", 32'({r1, g1, b1, r2, g2, b2}), 0);
      check("rst_addr0", 32'(rd_addr), 0);
      display = 1'b1;
      @(negedge pixclk);
      check("rst_addr_page1", 32'(rd_addr), 32'h200);
      display = 1'b0;
      @(negedge pixclk);
      check("rst_addr_page0", 32'(rd_addr), 0);

      // frame A: solid red
      for (int i = 0; i < 1024; i++) mem[i] = 24'hFF0000;
      push_frame(1'b0);
      reset  = 1'b1;
      mon_en = 1'b1;
      wait_frame(1'b0, -1);

      // frame B: random image, writer flips the page mid-frame
      for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
      push_frame(1'b0);
      wait_frame(1'b0, 2000);

      // frame C: single-pixel pattern on page 1
      for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
      mem[{1'b1, 4'd3, 5'd5}]  = 24'h800000;
      mem[{1'b1, 4'd11, 5'd5}] = 24'h100000;
      ones_r1 = 0;
      ones_r2 = 0;
      push_frame(1'b1);
      wait_frame(1'b1, -1);
      check("r1_ones", ones_r1, 1);
      check("r2_ones", ones_r2, 1);

      // frame D: aborted by a one-cycle reset during SHOW of row 5
      for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
      push_frame(1'b1);
      found = 1'b0;
      for (int n = 0; n < 6000 && !found; n++) begin
         @(negedge pixclk);
         if (row_sel == 3'd5 && !oe_n) found = 1'b1;
      end
      check("row5_show_seen", 32'(found), 1);
      #2;
      reset  = 1'b0;
      mon_en = 1'b0;
      #1;
      check("abort_oe_n", 32'(oe_n), 1);
      check("abort_row_sel", 32'(row_sel), 0);
      @(negedge pixclk);
      check("post_rst_oe_n", 32'(oe_n), 1);
      check("post_rst_row_sel", 32'(row_sel), 0);
      check("post_rst_addr", 32'(rd_addr), 32'h200);
      exp_bits.delete();
      exp_show.delete();
      exp_row.delete();
      push_frame(1'b1);
      reset = 1'b1;
      @(negedge pixclk);
      mon_en = 1'b1;
      wait_frame(1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
